// File: rtl/udp_frame_tx.sv
// udp_frame_tx: emits one Ethernet II / IPv4 / UDP frame per accepted start, byte by byte.
// Define UDP_FRAME_TX_PAD_EN to zero-pad short payloads up to the 64-byte minimum frame.
module udp_frame_tx #(
    parameter int TTL         = 64,
    parameter int MAX_PAYLOAD = 1472,
    parameter int IFG_BYTES   = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [47:0] dest_mac,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic [31:0] dest_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dest_port,
    input  logic [15:0] payload_len,
    output logic        busy,
    output logic        len_err,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last
);
    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_ETH, S_IP, S_UDP, S_PAY, S_PAD, S_FCS, S_IFG
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);
    localparam logic [15:0] IFG_END = 16'(IFG_BYTES - 1);

    state_t      state_q, state_d, after_pay;
    logic [15:0] cnt_q, cnt_d;
    logic [47:0] dmac_q, smac_q;
    logic [31:0] sip_q, dip_q;
    logic [15:0] sport_q, dport_q, len_q;
    logic [15:0] id_q, csum_q, csum_d;
    logic [31:0] crc_q, crc_n;
    logic        len_err_q;
    logic        accept, fire;
    logic [15:0] tot_len, udp_len;
    logic [41:0][7:0] hdr;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign accept  = (state_q == S_IDLE) && start && (payload_len <= MAX_LEN);
    assign fire    = tx_valid && tx_ready;
    assign busy    = (state_q != S_IDLE);
    assign len_err = len_err_q;
    assign tot_len = len_q + 16'd28;
    assign udp_len = len_q + 16'd8;
    assign crc_n   = ~crc_q;

    // Byte 0 of the header (first dest_mac byte) sits at hdr[41].
    assign hdr = {dmac_q, smac_q, 16'h0800,
                  8'h45, 8'h00, tot_len, id_q, 16'h4000, 8'(TTL), 8'h11, csum_q, sip_q, dip_q,
                  sport_q, dport_q, udp_len, 16'h0000};

`ifdef UDP_FRAME_TX_PAD_EN
    assign after_pay = (len_q < 16'd18) ? S_PAD : S_FCS;
`else
    assign after_pay = S_FCS;
`endif

    always_comb begin
        logic [19:0] sum;
        logic [16:0] fold;
        sum = 20'h04500 + 20'(tot_len) + 20'(id_q) + 20'h04000 + 20'({8'(TTL), 8'h11})
            + 20'(sip_q[31:16]) + 20'(sip_q[15:0]) + 20'(dip_q[31:16]) + 20'(dip_q[15:0]);
        fold   = 17'(sum[15:0]) + 17'(sum[19:16]);
        fold   = 17'(fold[15:0]) + 17'(fold[16]);
        csum_d = ~fold[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (accept) begin state_d = S_PRE; cnt_d = '0; end
            S_PRE: if (fire) begin
                if (cnt_q == 16'd7) begin state_d = S_ETH; cnt_d = '0; end
                else cnt_d = cnt_q + 16'd1;
            end
            S_ETH: if (fire) begin
                if (cnt_q == 16'd13) begin state_d = S_IP; cnt_d = '0; end
                else cnt_d = cnt_q + 16'd1;
            end
            S_IP: if (fire) begin
                if (cnt_q == 16'd19) begin state_d = S_UDP; cnt_d = '0; end
                else cnt_d = cnt_q + 16'd1;
            end
            S_UDP: if (fire) begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'd7) begin
                    state_d = (len_q != 16'd0) ? S_PAY : after_pay;
                    cnt_d   = '0;
                end
            end
            S_PAY: if (fire) begin
                if (cnt_q == len_q - 16'd1) begin state_d = after_pay; cnt_d = '0; end
                else cnt_d = cnt_q + 16'd1;
            end
`ifdef UDP_FRAME_TX_PAD_EN
            S_PAD: if (fire) begin
                if (cnt_q == 16'd17 - len_q) begin state_d = S_FCS; cnt_d = '0; end
                else cnt_d = cnt_q + 16'd1;
            end
`endif
            S_FCS: if (fire) begin
                if (cnt_q == 16'd3) begin state_d = S_IFG; cnt_d = '0; end
                else cnt_d = cnt_q + 16'd1;
            end
            S_IFG: if (tx_ready) begin
                if (cnt_q == IFG_END) begin state_d = S_IDLE; cnt_d = '0; end
                else cnt_d = cnt_q + 16'd1;
            end
            default: begin state_d = S_IDLE; cnt_d = '0; end
        endcase
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        pl_ready = 1'b0;
        case (state_q)
            S_PRE: begin tx_valid = 1'b1; tx_data = (cnt_q == 16'd7) ? 8'hD5 : 8'h55; end
            S_ETH: begin tx_valid = 1'b1; tx_data = hdr[6'd41 - cnt_q[5:0]]; end
            S_IP:  begin tx_valid = 1'b1; tx_data = hdr[6'd27 - cnt_q[5:0]]; end
            S_UDP: begin tx_valid = 1'b1; tx_data = hdr[6'd7 - cnt_q[5:0]]; end
            S_PAY: begin tx_valid = pl_valid; tx_data = pl_data; pl_ready = tx_ready; end
`ifdef UDP_FRAME_TX_PAD_EN
            S_PAD: tx_valid = 1'b1;
`endif
            S_FCS: begin
                tx_valid = 1'b1;
                tx_data  = crc_n[{cnt_q[1:0], 3'b000} +: 8];
                tx_last  = (cnt_q == 16'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            dmac_q    <= '0;
            smac_q    <= '0;
            sip_q     <= '0;
            dip_q     <= '0;
            sport_q   <= '0;
            dport_q   <= '0;
            len_q     <= '0;
            id_q      <= '0;
            csum_q    <= '0;
            crc_q     <= '1;
            len_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            len_err_q <= (state_q == S_IDLE) && start && (payload_len > MAX_LEN);
            if (accept) begin
                dmac_q  <= dest_mac;
                smac_q  <= src_mac;
                sip_q   <= src_ip;
                dip_q   <= dest_ip;
                sport_q <= src_port;
                dport_q <= dest_port;
                len_q   <= payload_len;
                crc_q   <= '1;
            end else if (fire && (state_q inside {S_ETH, S_IP, S_UDP, S_PAY, S_PAD})) begin
                crc_q <= crc_byte(crc_q, tx_data);
            end
            // Identification advances once the last FCS byte has left.
            if (fire && tx_last) id_q <= id_q + 16'd1;
        end
    end
endmodule
